ahb_sram_slave: RTL

AHB-Lite responder with an internal word-organised SRAM, the completion side for the team's AHB master. It accepts pipelined address and data phases: single and burst transfers, byte, halfword and word sizes, and a configurable number of wait states. Illegal accesses get the two-cycle ERROR response. It sits on the AHB bus behind the decoder's HSEL, as the memory target for master-driven ALU and register-file traffic.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_sram_bytelane_mem.sv | 32 +++
 rtl/ahb_sram_slave.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ============================================================================
// ahb_pkg : shared AHB-Lite codes, responder state encoding, lane helper
// Rev 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_DATA = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   // Little-endian lane mask for an aligned access of the given size.
   function automatic logic [3:0] byte_enables(input logic [2:0] size, input logic [1:0] lane);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << lane;
         HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_bytelane_mem.sv
// ============================================================================
// ahb_sram_bytelane_mem : 32-bit word array, per-byte write enable, async read
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_sram_bytelane_mem #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic [3:0]            we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];

   // Contents are deliberately left uninitialised and unaffected by reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// ahb_sram_slave : AHB-Lite responder backed by an internal word SRAM
// Rev 1.0
// ============================================================================
`default_nettype none

module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam logic [32:0] WINDOW_BYTES = 33'd1 << (ADDR_WIDTH + 2);
   localparam logic [3:0]  WAIT_INIT    = 4'(WAIT_STATES);

   state_t                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [3:0]            be_q;
   logic                  write_q;
   logic                  ready_q;
   logic                  resp_q;

   logic                  w_accept;
   logic [31:0]           w_offset;
   logic                  w_out_of_window;
   logic                  w_misaligned;
   logic                  w_error;
   logic [3:0]            w_we;
   logic [31:0]           w_rdata;
   logic                  w_unused_bits;

   assign w_accept        = HSEL & HREADY & HTRANS[1];
   assign w_offset        = HADDR - BASE_ADDR;
   // Addresses below the base wrap to a huge offset and fail the same test.
   assign w_out_of_window = ({1'b0, w_offset} >= WINDOW_BYTES);

   always_comb begin
      w_misaligned = 1'b0;
      case (HSIZE)
         HSIZE_HALF: w_misaligned = HADDR[0];
         HSIZE_WORD: w_misaligned = |HADDR[1:0];
         default:    w_misaligned = 1'b0;
      endcase
   end

   assign w_error       = (HSIZE > HSIZE_WORD) | w_misaligned | w_out_of_window;
   assign w_unused_bits = ^{HBURST, HTRANS[0]};

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         be_q    <= 4'b0000;
         write_q <= 1'b0;
         ready_q <= 1'b1;
         resp_q  <= HRESP_OKAY;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q <= S_DATA;
                  ready_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_ERR1: begin
               state_q <= S_ERR2;
               ready_q <= 1'b1;
               resp_q  <= HRESP_ERROR;
            end
            default: begin
               // S_IDLE, S_DATA and S_ERR2 all present HREADYOUT=1 and can take a new address phase.
               if (w_accept) begin
                  idx_q   <= w_offset[ADDR_WIDTH+1:2];
                  be_q    <= byte_enables(HSIZE, HADDR[1:0]);
                  write_q <= HWRITE;
                  if (w_error) begin
                     state_q <= S_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= HRESP_ERROR;
                  end else if (WAIT_STATES == 0) begin
                     state_q <= S_DATA;
                     ready_q <= 1'b1;
                     resp_q  <= HRESP_OKAY;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= WAIT_INIT;
                     ready_q <= 1'b0;
                     resp_q  <= HRESP_OKAY;
                  end
               end else begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= HRESP_OKAY;
               end
            end
         endcase
      end
   end

   assign w_we = (state_q == S_DATA && write_q) ? be_q : 4'b0000;

   ahb_sram_bytelane_mem #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (w_we),
      .addr_i  (idx_q),
      .wdata_i (HWDATA),
      .rdata_o (w_rdata)
   );

   assign HRDATA    = (state_q == S_DATA) ? w_rdata : 32'h0000_0000;
   assign HREADYOUT = ready_q;
   assign HRESP     = resp_q;

endmodule

`default_nettype wire
